snake_dir_ctrl: RTL and testbench

- Upstream input stage for the snake game core.
- Takes raw push buttons, then synchronizes and debounces them into the vga_clk domain.
- Applies the snake turning rules: no 180° reversal, and at most one direction change per movement step.
- Outputs the one-hot direction word the game logic consumes, plus one-cycle press pulses for the audio block.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_dir_ctrl_if.sv | 20 ++
 rtl/snake_dir_ctrl_btn_debounce.sv | 47 ++++
 rtl/snake_dir_ctrl.sv | 80 ++++++++
 tb/tb_snake_dir_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game input path.
// Direction encodings, button indices and the opposite-direction helper.
package snake_pkg;

  localparam logic [4:0] DIR_UP    = 5'b00001;
  localparam logic [4:0] DIR_DOWN  = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_RIGHT = 5'b01000;
  localparam logic [4:0] DIR_HOLD  = 5'b10000;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // HOLD has no opposite, so every arrow is legal from it.
  function automatic logic [4:0] opposite(input logic [4:0] d);
    logic [4:0] o;
    o = 5'b00000;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = 5'b00000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Button / game-core / direction bundle of the snake input stage.
// master = game core side, slave = snake_dir_ctrl.
interface snake_dir_ctrl_if;
  logic [4:0] btn_raw;
  logic       step_tick;
  logic       game_over;
  logic [4:0] dir;
  logic [4:0] press_evt;
  logic       new_game;

  modport master (
    output btn_raw, step_tick, game_over,
    input  dir, press_evt, new_game
  );

  modport slave (
    input  btn_raw, step_tick, game_over,
    output dir, press_evt, new_game
  );
endinterface

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// One button: 2-FF sync, stable-level debounce, rising-edge pulse.
// Any bounce back to the stable level restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 315000,
  parameter int CNT_W           = 19
) (
  input  logic vga_clk,
  input  logic wb_reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge vga_clk or posedge wb_reset) begin
    if (wb_reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_q         <= btn_i;
      s2_q         <= s1_q;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= s2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounced buttons in, one-hot dir out.
// Turns are checked against the direction about to be committed.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 315000,
  parameter int CNT_W           = 19
) (
  input logic             vga_clk,
  input logic             wb_reset,
  snake_dir_ctrl_if.slave bus
);

  logic [4:0] evt;
  logic [4:0] dir_q, dir_d;
  logic [4:0] pend_q, pend_d;
  logic       ng_q, ng_d;
  logic [4:0] ref_dir;
  logic [4:0] arrow;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .vga_clk (vga_clk),
      .wb_reset(wb_reset),
      .btn_i   (bus.btn_raw[i]),
      .press_o (evt[i])
    );
  end

  // Fixed priority among arrows: up > down > left > right.
  always_comb begin
    arrow = 5'b00000;
    if (evt[BTN_U])      arrow = DIR_UP;
    else if (evt[BTN_D]) arrow = DIR_DOWN;
    else if (evt[BTN_L]) arrow = DIR_LEFT;
    else if (evt[BTN_R]) arrow = DIR_RIGHT;
  end

  always_comb begin
    dir_d   = dir_q;
    pend_d  = pend_q;
    ng_d    = 1'b0;
    ref_dir = bus.step_tick ? pend_q : dir_q;
    if (bus.step_tick) dir_d = pend_q;
    if (evt[BTN_C]) begin
      dir_d  = DIR_HOLD;
      pend_d = DIR_HOLD;
      ng_d   = 1'b1;
    end else if (arrow != 5'b00000 &&
                 !bus.game_over &&
                 arrow != opposite(ref_dir)) begin
      pend_d = arrow;
    end
  end

  always_ff @(posedge vga_clk or posedge wb_reset) begin
    if (wb_reset) begin
      dir_q  <= DIR_HOLD;
      pend_q <= DIR_HOLD;
      ng_q   <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      pend_q <= pend_d;
      ng_q   <= ng_d;
    end
  end

  assign bus.dir       = dir_q;
  assign bus.press_evt = evt;
  assign bus.new_game  = ng_q;

  a_onehot: assert property (
    @(posedge vga_clk) disable iff (wb_reset)
    $onehot(dir_q) && $onehot(pend_q)
  );

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with a 4-cycle debounce.
// Vector table, hand sequences, then random ops vs a direction model.
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  logic vga_clk  = 1'b0;
  logic wb_reset = 1'b1;
  always #5 vga_clk = ~vga_clk;

  snake_dir_ctrl_if bus();

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .vga_clk (vga_clk),
    .wb_reset(wb_reset),
    .bus     (bus.slave)
  );

  int pass_n  = 0;
  int total_n = 0;
  int evt_cnt[5];
  int ng_cnt = 0;

  initial for (int i = 0; i < 5; i++) evt_cnt[i] = 0;

  always @(posedge vga_clk) begin
    for (int i = 0; i < 5; i++)
      if (bus.press_evt[i]) evt_cnt[i] <= evt_cnt[i] + 1;
    if (bus.new_game) ng_cnt <= ng_cnt + 1;
  end

  task automatic chk(string name, int act, int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s actual=%0h required=%0h",
                  name, act, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.step_tick = 1'b1;
    cyc(1);
    bus.step_tick = 1'b0;
  endtask

  task automatic press(int idx);
    bus.btn_raw[idx] = 1'b1;
    cyc(9);
    bus.btn_raw[idx] = 1'b0;
    cyc(9);
  endtask

  task automatic wait_evt(int idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (bus.press_evt[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [4:0] d2oh(int d);
    return (d == 0) ? DIR_HOLD : 5'(1 << (d - 1));
  endfunction

  function automatic int opp_d(int d);
    if (d == 0) return -1;
    return (d % 2 == 1) ? d + 1 : d - 1;
  endfunction

  typedef struct {
    int         act;
    int         idx;
    logic       go;
    logic [4:0] edir;
    logic [4:0] epend;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit ok;
    int first_k, pulses, e0, e1, n0;
    int md, mp, mgo, op, b, len;
    int mev[5];
    int mng;
    int b2d[5];

    bus.btn_raw   = 5'b0;
    bus.step_tick = 1'b0;
    bus.game_over = 1'b0;
    cyc(3);
    wb_reset = 1'b0;
    cyc(2);

    chk("rst_dir", int'(bus.dir), int'(DIR_HOLD));
    chk("rst_pend", int'(dut.pend_q), int'(DIR_HOLD));
    chk("rst_evt", int'(bus.press_evt), 0);
    chk("rst_ng", int'(bus.new_game), 0);

    // Latency and single pulse on a held up button.
    first_k = -1;
    pulses  = 0;
    bus.btn_raw[BTN_U] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (bus.press_evt[BTN_U]) begin
        if (first_k < 0) first_k = k;
        pulses++;
      end
    end
    bus.btn_raw[BTN_U] = 1'b0;
    cyc(9);
    chk("lat_up", first_k, 7);
    chk("pulses_up", pulses, 1);
    chk("pend_up", int'(dut.pend_q), int'(DIR_UP));
    tick();
    chk("dir_up", int'(bus.dir), int'(DIR_UP));

    e0 = evt_cnt[BTN_L];
    for (int k = 0; k < 8; k++) begin
      bus.btn_raw[BTN_L] = ~bus.btn_raw[BTN_L];
      cyc(2);
    end
    cyc(8);
    chk("bounce_no_evt", evt_cnt[BTN_L], e0);

    tbl[0]  = '{0, BTN_R, 1'b0, DIR_UP,    DIR_RIGHT};
    tbl[1]  = '{1, 0,     1'b0, DIR_RIGHT, DIR_RIGHT};
    tbl[2]  = '{0, BTN_L, 1'b0, DIR_RIGHT, DIR_RIGHT};
    tbl[3]  = '{0, BTN_U, 1'b0, DIR_RIGHT, DIR_UP};
    tbl[4]  = '{1, 0,     1'b0, DIR_UP,    DIR_UP};
    tbl[5]  = '{0, BTN_L, 1'b0, DIR_UP,    DIR_LEFT};
    tbl[6]  = '{0, BTN_D, 1'b0, DIR_UP,    DIR_LEFT};
    tbl[7]  = '{0, BTN_R, 1'b0, DIR_UP,    DIR_RIGHT};
    tbl[8]  = '{1, 0,     1'b0, DIR_RIGHT, DIR_RIGHT};
    tbl[9]  = '{0, BTN_U, 1'b1, DIR_RIGHT, DIR_RIGHT};
    tbl[10] = '{0, BTN_D, 1'b1, DIR_RIGHT, DIR_RIGHT};
    tbl[11] = '{1, 0,     1'b1, DIR_RIGHT, DIR_RIGHT};
    tbl[12] = '{0, BTN_C, 1'b0, DIR_HOLD,  DIR_HOLD};
    tbl[13] = '{0, BTN_D, 1'b0, DIR_HOLD,  DIR_DOWN};
    tbl[14] = '{1, 0,     1'b0, DIR_DOWN,  DIR_DOWN};

    for (int i = 0; i < 15; i++) begin
      bus.game_over = tbl[i].go;
      if (tbl[i].act == 0) press(tbl[i].idx);
      else tick();
      chk($sformatf("tbl%0d_dir", i),
          int'(bus.dir), int'(tbl[i].edir));
      chk($sformatf("tbl%0d_pend", i),
          int'(dut.pend_q), int'(tbl[i].epend));
    end
    bus.game_over = 1'b0;

    // Right press coincident with tick: ref is pending (left).
    press(BTN_C);
    press(BTN_U);
    tick();
    press(BTN_L);
    bus.btn_raw[BTN_R] = 1'b1;
    wait_evt(BTN_R, ok);
    chk("evt_r_seen", int'(ok), 1);
    bus.step_tick = 1'b1;
    cyc(1);
    bus.step_tick = 1'b0;
    chk("coinc_dir", int'(bus.dir), int'(DIR_LEFT));
    chk("coinc_pend", int'(dut.pend_q), int'(DIR_LEFT));
    bus.btn_raw[BTN_R] = 1'b0;
    cyc(9);

    // Up and left together from hold: up wins.
    press(BTN_C);
    e0 = evt_cnt[BTN_U];
    e1 = evt_cnt[BTN_L];
    bus.btn_raw[BTN_U] = 1'b1;
    bus.btn_raw[BTN_L] = 1'b1;
    cyc(9);
    bus.btn_raw = 5'b0;
    cyc(9);
    chk("multi_pend", int'(dut.pend_q), int'(DIR_UP));
    chk("multi_evt_u", evt_cnt[BTN_U] - e0, 1);
    chk("multi_evt_l", evt_cnt[BTN_L] - e1, 1);

    // Dead game ignores arrows; center beats a same-cycle tick.
    bus.game_over = 1'b1;
    press(BTN_L);
    chk("go_pend", int'(dut.pend_q), int'(DIR_UP));
    n0 = ng_cnt;
    bus.btn_raw[BTN_C] = 1'b1;
    wait_evt(BTN_C, ok);
    chk("evt_c_seen", int'(ok), 1);
    bus.step_tick = 1'b1;
    cyc(1);
    bus.step_tick = 1'b0;
    chk("ctick_dir", int'(bus.dir), int'(DIR_HOLD));
    chk("ctick_pend", int'(dut.pend_q), int'(DIR_HOLD));
    chk("ctick_ng", int'(bus.new_game), 1);
    cyc(1);
    chk("ctick_ng_off", int'(bus.new_game), 0);
    bus.btn_raw[BTN_C] = 1'b0;
    cyc(9);
    chk("ng_once", ng_cnt - n0, 1);
    bus.game_over = 1'b0;

    // Asynchronous reset mid-run during a press pulse.
    press(BTN_R);
    tick();
    chk("pre_rst_dir", int'(bus.dir), int'(DIR_RIGHT));
    bus.btn_raw[BTN_U] = 1'b1;
    wait_evt(BTN_U, ok);
    chk("evt_u_seen", int'(ok), 1);
    #2;
    wb_reset = 1'b1;
    bus.btn_raw = 5'b0;
    #1;
    chk("arst_dir", int'(bus.dir), int'(DIR_HOLD));
    chk("arst_pend", int'(dut.pend_q), int'(DIR_HOLD));
    chk("arst_evt", int'(bus.press_evt), 0);
    cyc(3);
    wb_reset = 1'b0;
    e0 = evt_cnt[BTN_U];
    cyc(10);
    chk("post_rst_dir", int'(bus.dir), int'(DIR_HOLD));
    chk("post_rst_pend", int'(dut.pend_q), int'(DIR_HOLD));
    chk("post_rst_evt", evt_cnt[BTN_U] - e0, 0);

    // Random ops against a direction-level model.
    b2d = '{0, 1, 3, 4, 2};
    md  = 0;
    mp  = 0;
    mgo = 0;
    mng = ng_cnt;
    for (int i = 0; i < 5; i++) mev[i] = evt_cnt[i];
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        b = (op == 0) ? int'($urandom_range(0, 4)) : op;
        press(b);
        mev[b]++;
        if (b == 0) begin
          md = 0;
          mp = 0;
          mng++;
        end else if (mgo == 0 && b2d[b] != opp_d(md)) begin
          mp = b2d[b];
        end
      end else if (op <= 7) begin
        tick();
        md = mp;
      end else if (op == 8) begin
        mgo = (mgo == 0) ? 1 : 0;
        bus.game_over = mgo[0];
        cyc(1);
      end else begin
        b   = int'($urandom_range(0, 4));
        len = int'($urandom_range(1, 3));
        bus.btn_raw[b] = 1'b1;
        cyc(len);
        bus.btn_raw[b] = 1'b0;
        cyc(8);
      end
      chk($sformatf("rnd%0d_dir", n),
          int'(bus.dir), int'(d2oh(md)));
      chk($sformatf("rnd%0d_pend", n),
          int'(dut.pend_q), int'(d2oh(mp)));
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("rnd_evt%0d", i), evt_cnt[i], mev[i]);
    chk("rnd_ng", ng_cnt, mng);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
